// File: rtl/priority_enc8to3_seq_if.sv
// Handshake bundle for the sequential 8-to-3 priority encoder.
// Valid/ready: a code w is offered while z=1. It is consumed on the clock edge where z=1 and ack=1.
interface priority_enc8to3_seq_if;
  logic       en;
  logic       ld;
  logic [7:0] y;
  logic       ack;
  logic       rdy;
  logic [2:0] w;
  logic       z;
  logic       done;

  modport slave  (input  en, ld, y, ack, output rdy, w, z, done);
  modport master (output en, ld, y, ack, input  rdy, w, z, done);
endinterface

// File: rtl/priority_enc8to3_seq.sv
// Sequential 8-to-3 priority encoder. It captures a multi-hot vector and emits one code per
// accepted handshake, in priority order, then pulses done.
module priority_enc8to3_seq #(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    priority_enc8to3_seq_if.slave   bus,
    output logic                    dbg_scan_o
);

    typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t     state_q;
    logic [7:0] pend_q;
    logic       done_q;
    logic [2:0] sel_code;
    logic [7:0] pend_d;

    // The last set bit seen in the scan order wins, so the scan direction sets the priority.
    always_comb begin
        sel_code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (PRIORITY_HIGH) begin
                if (pend_q[i]) sel_code = 3'(i);
            end else begin
                if (pend_q[7 - i]) sel_code = 3'(7 - i);
            end
        end
        pend_d = pend_q & ~(8'b1 << sel_code);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            pend_q  <= 8'h00;
            done_q  <= 1'b0;
        end else if (bus.en) begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.ld && (bus.y != 8'h00)) begin
                        pend_q  <= bus.y;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.ack) begin
                        pend_q <= pend_d;
                        if (pend_d == 8'h00) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // When en is low, done_q is frozen along with everything else, so a pending pulse appears on re-enable.
    assign bus.rdy    = (state_q == IDLE);
    assign bus.z      = bus.en && (state_q == SCAN);
    assign bus.w      = (state_q == SCAN) ? sel_code : 3'd0;
    assign bus.done   = bus.en && done_q;
    assign dbg_scan_o = (state_q == SCAN);

endmodule

// File: tb/tb_priority_enc8to3_seq.sv
// Bench for priority_enc8to3_seq: two instances (high and low priority), one queue-style model.
module tb_priority_enc8to3_seq;

  logic       Clock;
  logic       Resetn;
  logic       en, ld, ack;
  logic [7:0] y;
  logic       dbg_h, dbg_l;

  int total = 0;
  int bad   = 0;

  priority_enc8to3_seq_if ifh ();
  priority_enc8to3_seq_if ifl ();

  assign ifh.en = en;  assign ifh.ld = ld;  assign ifh.y = y;  assign ifh.ack = ack;
  assign ifl.en = en;  assign ifl.ld = ld;  assign ifl.y = y;  assign ifl.ack = ack;

  priority_enc8to3_seq #(.PRIORITY_HIGH(1'b1)) dut_h (
    .Clock(Clock), .Resetn(Resetn), .bus(ifh.slave), .dbg_scan_o(dbg_h)
  );
  priority_enc8to3_seq #(.PRIORITY_HIGH(1'b0)) dut_l (
    .Clock(Clock), .Resetn(Resetn), .bus(ifl.slave), .dbg_scan_o(dbg_l)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: on capture, list the set indices in service order; each ack pops one code.
  // Instance 0 is the high-priority one, and instance 1 is the low-priority one.
  logic [2:0] ord [2][8];
  int         head [2];
  int         cnt  [2];
  bit         dflag[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      head[d] = 0; cnt[d] = 0; dflag[d] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (en) begin
        dflag[d] = 1'b0;
        if (cnt[d] == 0) begin
          if (ld && y != 8'h00) begin
            head[d] = 0;
            for (int i = 0; i < 8; i++) begin
              int b;
              b = (d == 0) ? 7 - i : i;
              if (y[b]) begin
                ord[d][cnt[d]] = 3'(b);
                cnt[d]++;
              end
            end
          end
        end else if (ack) begin
          head[d]++;
          cnt[d]--;
          if (cnt[d] == 0) dflag[d] = 1'b1;
        end
      end
    end
  endtask

  // Inputs change only just after posedge, so the values seen at negedge are the ones the next edge samples.
  initial begin
    model_reset();
    forever begin
      @(negedge Clock);
      if (!Resetn) model_reset();
      for (int d = 0; d < 2; d++) begin
        logic [7:0] ew;
        ew = (cnt[d] > 0) ? 8'(ord[d][head[d]]) : 8'd0;
        check(d == 0 ? "h_rdy"  : "l_rdy",  8'(d == 0 ? ifh.rdy  : ifl.rdy),  8'(cnt[d] == 0));
        check(d == 0 ? "h_z"    : "l_z",    8'(d == 0 ? ifh.z    : ifl.z),    8'(en && cnt[d] > 0));
        check(d == 0 ? "h_w"    : "l_w",    8'(d == 0 ? ifh.w    : ifl.w),    ew);
        check(d == 0 ? "h_done" : "l_done", 8'(d == 0 ? ifh.done : ifl.done), 8'(en && dflag[d]));
      end
      if (Resetn) model_step();
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input logic [7:0] v, input logic a);
    y = v; ld = 1'b1; ack = a;
    cyc();
    ld = 1'b0;
  endtask

  initial begin
    Resetn = 1'b0; en = 1'b1; ld = 1'b0; ack = 1'b0; y = 8'h00;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_rdy", 8'(ifh.rdy), 8'd1);
    check("rst_z",   8'(ifh.z),   8'd0);
    Resetn = 1'b1;
    cyc();

    // basic: 0x85 with ack held high
    load(8'h85, 1'b1);
    check("t2_w7", 8'(ifh.w), 8'd7);
    check("t2_z",  8'(ifh.z), 8'd1);
    cyc(); check("t2_w2", 8'(ifh.w), 8'd2);
    cyc(); check("t2_w0", 8'(ifh.w), 8'd0);
    cyc(); check("t2_done", 8'(ifh.done), 8'd1);
    check("t2_rdy", 8'(ifh.rdy), 8'd1);
    ack = 1'b0;
    cyc(); check("t2_done_clr", 8'(ifh.done), 8'd0);

    // backpressure
    load(8'h30, 1'b0);
    repeat (5) begin
      check("t3_hold_w", 8'(ifh.w), 8'd5);
      check("t3_hold_z", 8'(ifh.z), 8'd1);
      cyc();
    end
    ack = 1'b1;
    cyc(); check("t3_w4", 8'(ifh.w), 8'd4);
    cyc(); check("t3_done", 8'(ifh.done), 8'd1);
    ack = 1'b0;
    cyc();

    // zero load ignored, load ignored during scan and on the final ack
    load(8'h00, 1'b0);
    check("t4_zero_rdy", 8'(ifh.rdy), 8'd1);
    check("t4_zero_z",   8'(ifh.z),   8'd0);
    load(8'h11, 1'b1);
    check("t4_w4", 8'(ifh.w), 8'd4);
    y = 8'hFF; ld = 1'b1;
    cyc(); check("t4_w0_no_reload", 8'(ifh.w), 8'd0);
    cyc(); check("t4_done", 8'(ifh.done), 8'd1);
    ld = 1'b0; ack = 1'b0;
    cyc(); check("t4_idle", 8'(ifh.rdy), 8'd1);

    // enable freeze
    load(8'h0E, 1'b1);
    check("t5_w3", 8'(ifh.w), 8'd3);
    cyc(); check("t5_w2", 8'(ifh.w), 8'd2);
    en = 1'b0;
    #1; check("t5_z_off", 8'(ifh.z), 8'd0);
    repeat (3) begin
      cyc();
      check("t5_frozen_w", 8'(ifh.w), 8'd2);
      check("t5_frozen_rdy", 8'(ifh.rdy), 8'd0);
    end
    en = 1'b1;
    #1; check("t5_resume_w", 8'(ifh.w), 8'd2);
    cyc(); check("t5_w1", 8'(ifh.w), 8'd1);
    cyc(); check("t5_done", 8'(ifh.done), 8'd1);
    ack = 1'b0;
    cyc();

    // both priority settings on 0x81
    load(8'h81, 1'b1);
    check("t6_lo_w0", 8'(ifl.w), 8'd0);
    check("t6_hi_w7", 8'(ifh.w), 8'd7);
    cyc();
    check("t6_lo_w7", 8'(ifl.w), 8'd7);
    check("t6_hi_w0", 8'(ifh.w), 8'd0);
    cyc();
    check("t6_lo_done", 8'(ifl.done), 8'd1);
    check("t6_hi_done", 8'(ifh.done), 8'd1);
    ack = 1'b0;
    cyc();

    // asynchronous reset in the middle of a scan
    load(8'hFF, 1'b0);
    cyc();
    #2 Resetn = 1'b0;
    #1;
    check("t1_z",    8'(ifh.z),    8'd0);
    check("t1_rdy",  8'(ifh.rdy),  8'd1);
    check("t1_w",    8'(ifh.w),    8'd0);
    check("t1_done", 8'(ifh.done), 8'd0);
    cyc();
    Resetn = 1'b1;
    cyc();

    // all nonzero vectors, ack held high, then again with random ack
    for (int v = 1; v < 256; v++) begin
      load(8'(v), 1'b1);
      repeat (9) cyc();
    end
    ack = 1'b0;
    cyc();
    for (int v = 1; v < 256; v++) begin
      load(8'(v), 1'($urandom_range(0, 1)));
      repeat (12) begin
        ack = 1'($urandom_range(0, 1));
        en  = ($urandom_range(0, 7) != 0);
        cyc();
      end
      en = 1'b1; ack = 1'b1;
      repeat (9) cyc();
      ack = 1'b0;
    end
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
